// File: rtl/uart_host_ctrl.sv
// Bus master for the uart register block: boots it, polls STATUS, arbitrates TX
// requesters round-robin onto TXDATA and forwards received bytes to one sink.
module uart_host_ctrl #(
    parameter int          NREQ         = 2,
    parameter int          CPU_CLOCK_HZ = 50_000_000,
    parameter logic [15:0] BAUD_DIV     = 16'(CPU_CLOCK_HZ / 115200),
    parameter logic [1:0]  CTRL_INIT    = 2'b11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid_i,
    input  logic [NREQ*8-1:0] req_data_i,
    output logic [NREQ-1:0]   req_ready_o,
    output logic              rx_valid_o,
    output logic [7:0]        rx_data_o,
    output logic              boot_done_o,
    output logic [7:0]        uart_waddr_o,
    output logic [31:0]       uart_wdata_o,
    output logic [3:0]        uart_sel_o,
    output logic              uart_we_o,
    output logic [7:0]        uart_raddr_o,
    output logic              uart_rd_o,
    input  logic [31:0]       uart_rdata_i
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [7:0] A_CTRL   = 8'h00;
    localparam logic [7:0] A_STATUS = 8'h04;
    localparam logic [7:0] A_BAUD   = 8'h08;
    localparam logic [7:0] A_TXDATA = 8'h0C;
    localparam logic [7:0] A_RXDATA = 8'h10;

    typedef enum logic [3:0] {
        S_BOOT,
        S_INIT_B,
        S_INIT_C,
        S_IDLE,
        S_POLL_RD,
        S_POLL_CHK,
        S_TX_WR,
        S_RX_RD,
        S_RX_CAP,
        S_RX_CLR
    } state_t;

    state_t          state_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   grant_q;
    logic [7:0]      rx_data_q;
    logic            rx_valid_q;
    logic            boot_done_q;

    logic [PW-1:0]   pick;
    logic [PW-1:0]   idx;
    logic            any_valid;
    logic            tx_ok;
    logic [PW-1:0]   ptr_d;
    logic [7:0]      req_byte [NREQ];
    logic            unused_rdata;

    assign unused_rdata = ^uart_rdata_i[31:8];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_bytes
        assign req_byte[gi] = req_data_i[8*gi +: 8];
    end

    // Scan from the highest offset down so the nearest valid index at/after the pointer wins.
    always_comb begin
        pick      = '0;
        idx       = '0;
        any_valid = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = PW'((int'(ptr_q) + i) % NREQ);
            if (req_valid_i[idx]) begin
                pick      = idx;
                any_valid = 1'b1;
            end
        end
    end

    // A requester that drops valid before its write slot withdraws the byte.
    assign tx_ok = (state_q == S_TX_WR) && req_valid_i[grant_q];
    assign ptr_d = (grant_q == PW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        uart_waddr_o = '0;
        uart_wdata_o = '0;
        uart_sel_o   = '0;
        uart_we_o    = 1'b0;
        uart_raddr_o = '0;
        uart_rd_o    = 1'b0;
        req_ready_o  = '0;
        case (state_q)
            S_INIT_B: begin
                uart_we_o    = 1'b1;
                uart_waddr_o = A_BAUD;
                uart_wdata_o = {16'h0, BAUD_DIV};
                uart_sel_o   = 4'b0011;
            end
            S_INIT_C: begin
                uart_we_o    = 1'b1;
                uart_waddr_o = A_CTRL;
                uart_wdata_o = {30'h0, CTRL_INIT};
                uart_sel_o   = 4'b0001;
            end
            S_POLL_RD: begin
                uart_rd_o    = 1'b1;
                uart_raddr_o = A_STATUS;
            end
            S_TX_WR: begin
                uart_we_o            = tx_ok;
                uart_waddr_o         = A_TXDATA;
                uart_wdata_o         = {24'h0, req_byte[grant_q]};
                uart_sel_o           = 4'b0001;
                req_ready_o[grant_q] = tx_ok;
            end
            S_RX_RD: begin
                uart_rd_o    = 1'b1;
                uart_raddr_o = A_RXDATA;
            end
            S_RX_CLR: begin
                uart_we_o    = 1'b1;
                uart_waddr_o = A_STATUS;
                uart_sel_o   = 4'b0001;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_BOOT;
            ptr_q       <= '0;
            grant_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            boot_done_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                S_BOOT:    state_q <= S_INIT_B;
                S_INIT_B:  state_q <= S_INIT_C;
                S_INIT_C: begin
                    boot_done_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                S_IDLE:    state_q <= S_POLL_RD;
                S_POLL_RD: state_q <= S_POLL_CHK;
                // RX wins over TX, but neither touches STATUS/TXDATA while TX is busy.
                S_POLL_CHK: begin
                    if (uart_rdata_i[0]) begin
                        state_q <= S_IDLE;
                    end else if (uart_rdata_i[1]) begin
                        state_q <= S_RX_RD;
                    end else if (any_valid) begin
                        grant_q <= pick;
                        state_q <= S_TX_WR;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_TX_WR: begin
                    if (tx_ok) ptr_q <= ptr_d;
                    state_q <= S_IDLE;
                end
                S_RX_RD:   state_q <= S_RX_CAP;
                S_RX_CAP: begin
                    rx_data_q  <= uart_rdata_i[7:0];
                    rx_valid_q <= 1'b1;
                    state_q    <= S_RX_CLR;
                end
                S_RX_CLR:  state_q <= S_IDLE;
                default:   state_q <= S_BOOT;
            endcase
        end
    end

    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;
    assign boot_done_o = boot_done_q;

endmodule
